// File: rtl/mem_arb_pkg.sv
// Shared constants, state encoding and index helpers for mem_arbiter.
package mem_arb_pkg;

   localparam int unsigned DEF_ADDR_W = 16;
   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned MAX_NREQ   = 8;

   typedef enum logic [0:0] {
      ARB_FREE,
      ARB_LOCKED
   } arb_state_e;

   // Index reached by stepping 'off' places from 'base' in a ring of 'n' slots.
   // Callers keep base < n and off < n, so one subtraction is enough.
   function automatic int unsigned wrap_idx(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
      int unsigned sum;
      sum = base + off;
      return (sum >= n) ? (sum - n) : sum;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after i_ptr wins.
module mem_arbiter_rr_pick
   import mem_arb_pkg::*;
#(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_gnt,
   output logic [PTR_W-1:0] o_idx,
   output logic             o_valid
);

   // Scan from the pointer, wrapping, and stop at the first hit.
   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!o_valid && i_req[wrap_idx(int'(i_ptr), k, NREQ)]) begin
            o_valid = 1'b1;
            o_gnt[wrap_idx(int'(i_ptr), k, NREQ)] = 1'b1;
            o_idx = PTR_W'(wrap_idx(int'(i_ptr), k, NREQ));
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-read memory among NREQ clients.
// Optional MEM_ARB_LOCK_EN adds a per-requester lock input that pins the grant to
// one requester for atomic read-modify-write sequences.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NREQ   = 2,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [NREQ-1:0]        i_req,
   input  logic [NREQ-1:0]        i_req_we,
   input  logic [NREQ*ADDR_W-1:0] i_req_addr,
   input  logic [NREQ*DATA_W-1:0] i_req_wdata,
`ifdef MEM_ARB_LOCK_EN
   input  logic [NREQ-1:0]        i_lock,
`endif
   output logic [NREQ-1:0]        o_gnt,
   output logic [NREQ-1:0]        o_rvalid,
   output logic [DATA_W-1:0]      o_rdata,
   output logic [ADDR_W-1:0]      o_mem_addr,
   output logic [DATA_W-1:0]      o_mem_data_in,
   output logic                   o_mem_we,
   output logic                   o_mem_re,
   input  logic [DATA_W-1:0]      i_mem_data_out
);

   localparam int unsigned PTR_W = $clog2(NREQ);

   if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
      $error("mem_arbiter: NREQ must be in 2..%0d", MAX_NREQ);
   end

   logic [PTR_W-1:0] r_ptr;
   logic [NREQ-1:0]  r_rd_owner;

   logic [NREQ-1:0]  w_req_eff;
   logic [NREQ-1:0]  w_pick_gnt;
   logic [PTR_W-1:0] w_idx;
   logic             w_pick_valid;
   logic             w_grant;
   logic [PTR_W-1:0] w_ptr_next;

`ifdef MEM_ARB_LOCK_EN
   arb_state_e       r_state;
   logic [PTR_W-1:0] r_lock_idx;

   // While locked only the lock owner can win; others are masked out.
   always_comb begin
      w_req_eff = i_req;
      if (r_state == ARB_LOCKED) begin
         w_req_eff = i_req & (NREQ'(1) << r_lock_idx);
      end
   end
`else
   assign w_req_eff = i_req;
`endif

   mem_arbiter_rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .i_req   (w_req_eff),
      .i_ptr   (r_ptr),
      .o_gnt   (w_pick_gnt),
      .o_idx   (w_idx),
      .o_valid (w_pick_valid)
   );

   assign w_grant    = w_pick_valid && !i_rst;
   assign w_ptr_next = PTR_W'(wrap_idx(int'(w_idx), 1, NREQ));

   // Memory command straight from the winner; idle drives zeros.
   always_comb begin
      o_gnt         = '0;
      o_mem_addr    = '0;
      o_mem_data_in = '0;
      o_mem_we      = 1'b0;
      o_mem_re      = 1'b0;
      if (w_grant) begin
         o_gnt      = w_pick_gnt;
         o_mem_addr = i_req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
         if (i_req_we[w_idx]) begin
            o_mem_we      = 1'b1;
            o_mem_data_in = i_req_wdata[int'(w_idx)*DATA_W +: DATA_W];
         end else begin
            o_mem_re = 1'b1;
         end
      end
   end

   // Reset masks rvalid immediately so an in-flight read is dropped the same cycle.
   assign o_rvalid = i_rst ? '0 : r_rd_owner;
   assign o_rdata  = i_mem_data_out;

   // Pointer, lock state and read-owner tag updates.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr      <= '0;
         r_rd_owner <= '0;
`ifdef MEM_ARB_LOCK_EN
         r_state    <= ARB_FREE;
         r_lock_idx <= '0;
`endif
      end else begin
         r_rd_owner <= o_mem_re ? (o_gnt & ~i_req_we) : '0;
`ifdef MEM_ARB_LOCK_EN
         case (r_state)
            ARB_FREE: begin
               if (w_grant) begin
                  r_ptr <= w_ptr_next;
                  if (i_lock[w_idx]) begin
                     r_state    <= ARB_LOCKED;
                     r_lock_idx <= w_idx;
                  end
               end
            end
            ARB_LOCKED: begin
               // Pointer stays frozen until the owner releases the lock.
               if (!i_lock[r_lock_idx]) begin
                  r_state <= ARB_FREE;
                  r_ptr   <= PTR_W'(wrap_idx(int'(r_lock_idx), 1, NREQ));
               end
            end
            default: r_state <= ARB_FREE;
         endcase
`else
         if (w_grant) begin
            r_ptr <= w_ptr_next;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (NREQ=2) with a behavioural 1-cycle-read memory.
// Lock sequence runs only when MEM_ARB_LOCK_EN is defined.
module tb_mem_arbiter;

   localparam int unsigned NREQ   = 2;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   logic                   clk;
   logic                   rst;
   logic [NREQ-1:0]        req;
   logic [NREQ-1:0]        req_we;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_wdata;
   logic [NREQ-1:0]        lock;
   logic [NREQ-1:0]        gnt;
   logic [NREQ-1:0]        rvalid;
   logic [DATA_W-1:0]      rdata;
   logic [ADDR_W-1:0]      mem_addr;
   logic [DATA_W-1:0]      mem_data_in;
   logic                   mem_we;
   logic                   mem_re;
   logic [DATA_W-1:0]      mem_data_out;

   int checks;
   int errors;

   mem_arbiter #(
      .NREQ   (NREQ),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_req          (req),
      .i_req_we       (req_we),
      .i_req_addr     (req_addr),
      .i_req_wdata    (req_wdata),
`ifdef MEM_ARB_LOCK_EN
      .i_lock         (lock),
`endif
      .o_gnt          (gnt),
      .o_rvalid       (rvalid),
      .o_rdata        (rdata),
      .o_mem_addr     (mem_addr),
      .o_mem_data_in  (mem_data_in),
      .o_mem_we       (mem_we),
      .o_mem_re       (mem_re),
      .i_mem_data_out (mem_data_out)
   );

   // Behavioural single-port memory: registered read, initial content addr[7:0]^0x3C.
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   initial begin
      for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'(a) ^ 8'h3C;
      mem_data_out = '0;
   end
   always @(posedge clk) begin
      if (mem_re) mem_data_out <= mem[mem_addr];
      else if (mem_we) mem[mem_addr] <= mem_data_in;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [1:0]  req;
      logic [1:0]  we;
      logic [15:0] a0;
      logic [15:0] a1;
      logic [7:0]  d0;
      logic [7:0]  d1;
      logic [1:0]  e_gnt;
      logic        e_we;
      logic        e_re;
      logic [15:0] e_addr;
      logic [7:0]  e_din;
      logic [1:0]  e_rv;
      logic [7:0]  e_rd;
   } vec_t;

   localparam int NVEC = 24;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic [1:0] w,
                               input logic [15:0] a0, input logic [15:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [1:0] eg, input logic ew, input logic er,
                               input logic [15:0] ea, input logic [7:0] ed,
                               input logic [1:0] erv, input logic [7:0] erd);
      vec_t v;
      v.rst = r; v.req = rq; v.we = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
      v.e_gnt = eg; v.e_we = ew; v.e_re = er; v.e_addr = ea; v.e_din = ed;
      v.e_rv = erv; v.e_rd = erd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive at the falling edge; outputs are compared 2 ns later, well before the rising edge.
   task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] w,
                        input logic [15:0] a0, input logic [15:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] lk);
      @(negedge clk);
      rst = r; req = rq; req_we = w;
      req_addr = {a1, a0}; req_wdata = {d1, d0}; lock = lk;
      #2;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; lock = '0;

      //             rst rq    we    a0       a1       d0     d1     gnt   we re addr     din    rv    rd
      vecs[0]  = mk(1, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, 0, 0, 16'h0000, 8'h00, 2'b00, 8'h00);
      vecs[1]  = mk(1, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, 0, 0, 16'h0000, 8'h00, 2'b00, 8'h00);
      vecs[2]  = mk(0, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, 0, 0, 16'h0000, 8'h00, 2'b00, 8'h00);
      // single write then read of 0x0010
      vecs[3]  = mk(0, 2'b01, 2'b01, 16'h0010, 16'h0000, 8'hA5, 8'h00, 2'b01, 1, 0, 16'h0010, 8'hA5, 2'b00, 8'h00);
      vecs[4]  = mk(0, 2'b01, 2'b00, 16'h0010, 16'h0000, 8'h00, 8'h00, 2'b01, 0, 1, 16'h0010, 8'h00, 2'b00, 8'h00);
      vecs[5]  = mk(0, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, 0, 0, 16'h0000, 8'h00, 2'b01, 8'hA5);
      // contention, both reading; ptr is 1 here
      vecs[6]  = mk(0, 2'b11, 2'b00, 16'h0030, 16'h0041, 8'h00, 8'h00, 2'b10, 0, 1, 16'h0041, 8'h00, 2'b00, 8'h00);
      vecs[7]  = mk(0, 2'b11, 2'b00, 16'h0030, 16'h0041, 8'h00, 8'h00, 2'b01, 0, 1, 16'h0030, 8'h00, 2'b10, 8'h7D);
      vecs[8]  = mk(0, 2'b11, 2'b00, 16'h0030, 16'h0041, 8'h00, 8'h00, 2'b10, 0, 1, 16'h0041, 8'h00, 2'b01, 8'h0C);
      vecs[9]  = mk(0, 2'b11, 2'b00, 16'h0030, 16'h0041, 8'h00, 8'h00, 2'b01, 0, 1, 16'h0030, 8'h00, 2'b10, 8'h7D);
      vecs[10] = mk(0, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, 0, 0, 16'h0000, 8'h00, 2'b01, 8'h0C);
      // same-address ordering on 0x0020
      vecs[11] = mk(0, 2'b01, 2'b01, 16'h0020, 16'h0000, 8'h11, 8'h00, 2'b01, 1, 0, 16'h0020, 8'h11, 2'b00, 8'h00);
      vecs[12] = mk(0, 2'b10, 2'b00, 16'h0000, 16'h0020, 8'h00, 8'h00, 2'b10, 0, 1, 16'h0020, 8'h00, 2'b00, 8'h00);
      vecs[13] = mk(0, 2'b01, 2'b01, 16'h0020, 16'h0000, 8'h22, 8'h00, 2'b01, 1, 0, 16'h0020, 8'h22, 2'b10, 8'h11);
      vecs[14] = mk(0, 2'b10, 2'b00, 16'h0000, 16'h0020, 8'h00, 8'h00, 2'b10, 0, 1, 16'h0020, 8'h00, 2'b00, 8'h00);
      vecs[15] = mk(0, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, 0, 0, 16'h0000, 8'h00, 2'b10, 8'h22);
      // mixed write/read contention; ptr is 0
      vecs[16] = mk(0, 2'b11, 2'b01, 16'h0050, 16'h0060, 8'h5A, 8'h00, 2'b01, 1, 0, 16'h0050, 8'h5A, 2'b00, 8'h00);
      vecs[17] = mk(0, 2'b10, 2'b00, 16'h0000, 16'h0060, 8'h00, 8'h00, 2'b10, 0, 1, 16'h0060, 8'h00, 2'b00, 8'h00);
      vecs[18] = mk(0, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, 0, 0, 16'h0000, 8'h00, 2'b10, 8'h5C);
      // reset while a read is in flight; ptr must return to 0
      vecs[19] = mk(0, 2'b11, 2'b00, 16'h0030, 16'h0041, 8'h00, 8'h00, 2'b01, 0, 1, 16'h0030, 8'h00, 2'b00, 8'h00);
      vecs[20] = mk(1, 2'b11, 2'b00, 16'h0030, 16'h0041, 8'h00, 8'h00, 2'b00, 0, 0, 16'h0000, 8'h00, 2'b00, 8'h00);
      vecs[21] = mk(0, 2'b11, 2'b00, 16'h0030, 16'h0041, 8'h00, 8'h00, 2'b01, 0, 1, 16'h0030, 8'h00, 2'b00, 8'h00);
      vecs[22] = mk(0, 2'b11, 2'b00, 16'h0030, 16'h0041, 8'h00, 8'h00, 2'b10, 0, 1, 16'h0041, 8'h00, 2'b01, 8'h0C);
      vecs[23] = mk(0, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, 0, 0, 16'h0000, 8'h00, 2'b10, 8'h7D);

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].rst, vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1,
               vecs[i].d0, vecs[i].d1, 2'b00);
         chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
         chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
         chk($sformatf("v%0d mem_re", i), 32'(mem_re), 32'(vecs[i].e_re));
         chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
         chk($sformatf("v%0d mem_data_in", i), 32'(mem_data_in), 32'(vecs[i].e_din));
         chk($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(vecs[i].e_rv));
         if (vecs[i].e_rv != 2'b00) begin
            chk($sformatf("v%0d rdata", i), 32'(rdata), 32'(vecs[i].e_rd));
         end
      end

      // Single active requester is granted every cycle; writes land in memory.
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 2'b10, 2'b10, 16'h0000, 16'(16'h0070 + k), 8'h00, 8'(8'hC0 + k), 2'b00);
         chk($sformatf("solo%0d gnt", k), 32'(gnt), 32'(2'b10));
         chk($sformatf("solo%0d mem_we", k), 32'(mem_we), 32'h1);
      end
      drive(1'b0, 2'b01, 2'b00, 16'h0072, 16'h0000, 8'h00, 8'h00, 2'b00);
      chk("solo read gnt", 32'(gnt), 32'(2'b01));
      drive(1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00);
      chk("solo read rvalid", 32'(rvalid), 32'(2'b01));
      chk("solo read rdata", 32'(rdata), 32'h0000_00C2);

`ifdef MEM_ARB_LOCK_EN
      // Start from reset so ptr=0; requester 1 locks while requester 0 waits.
      drive(1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00);
      drive(1'b0, 2'b10, 2'b00, 16'h0000, 16'h0080, 8'h00, 8'h00, 2'b10);
      chk("lock a gnt", 32'(gnt), 32'(2'b10));
      drive(1'b0, 2'b11, 2'b00, 16'h0000, 16'h0080, 8'h00, 8'h00, 2'b10);
      chk("lock b gnt", 32'(gnt), 32'(2'b10));
      drive(1'b0, 2'b11, 2'b10, 16'h0000, 16'h0080, 8'h00, 8'h99, 2'b00);
      chk("lock c gnt", 32'(gnt), 32'(2'b10));
      drive(1'b0, 2'b11, 2'b00, 16'h0000, 16'h0081, 8'h00, 8'h00, 2'b00);
      chk("lock exit gnt", 32'(gnt), 32'(2'b01));
      drive(1'b0, 2'b11, 2'b00, 16'h0000, 16'h0081, 8'h00, 8'h00, 2'b00);
      chk("lock after gnt", 32'(gnt), 32'(2'b10));
`endif

      drive(1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
